alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be supported for any even value 8..64.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; SHALL clear all state immediately, independent of clk.
REQ-004 start  in  1  request; SHALL be sampled only when busy=0.
REQ-005 ALUControl  in  4  operation code, sampled with start.
REQ-006 srcA  in  WIDTH  operand A, sampled with start.
REQ-007 srcB  in  WIDTH  operand B, sampled with start.
REQ-008 res  out  WIDTH  registered result, held until the next done.
REQ-009 zero  out  1  registered flag, updated together with res.
REQ-010 busy  out  1  high while an iterative operation is in progress.
REQ-011 done  out  1  single-cycle pulse marking res/zero newly valid.

Function
REQ-012 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 EQ, 0101 SLT (signed), 0110 SLTU, 0111 XOR, 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU; 1100-1111 SHALL return res=srcA.
REQ-013 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-014 EQ/SLT/SLTU SHALL return res=1 when true, else 0, zero-extended to WIDTH.
REQ-015 zero SHALL equal res[0] for EQ/SLT/SLTU and (res==0) for all other opcodes.
REQ-016 FSM states SHALL be IDLE and BUSY only.
REQ-017 Single-cycle ops (0000-0111, 1100-1111): start accepted at edge k -> res, zero and done=1 after edge k; FSM stays IDLE.
REQ-018 Iterative ops (1000-1011): start accepted at edge k -> BUSY with busy=1 after edge k; one radix-2 step per edge k+1..k+WIDTH; after edge k+WIDTH, FSM=IDLE, busy=0, done=1 and res/zero valid.
REQ-019 MUL/MULHU SHALL use unsigned shift-add producing a 2*WIDTH product; opcode selects the half.
REQ-020 DIVU/REMU SHALL use unsigned restoring division; srcB=0 SHALL give DIVU res = all ones and REMU res = srcA, still after WIDTH iterations.
REQ-021 Operands SHALL be latched at acceptance; input changes while busy=1 SHALL NOT affect the result.
REQ-022 start while busy=1 SHALL be ignored, not queued.
REQ-023 done SHALL be high for exactly one cycle per accepted start, and SHALL be 0 in all other cycles.
REQ-024 start in the cycle done=1 (busy=0) SHALL be accepted; back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-025 res and zero SHALL hold their last value whenever done=0.
REQ-026 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap.

Reset
REQ-027 While reset=1: FSM=IDLE, busy=0, done=0, res=0, zero=0, counter and internal operand/accumulator registers=0.
REQ-028 Reset asserted mid-iteration SHALL abort the operation with no done pulse; the first clk edge after deassertion SHALL accept a new start.

Verification (WIDTH=32)
REQ-029 ADD 5,7 -> done after 1 edge, res=12, zero=0; then SUB 7,7 next cycle -> res=0, zero=1.
REQ-030 SLT 0xFFFFFFFF,1 -> res=1, zero=1; SLTU 0xFFFFFFFF,1 -> res=0, zero=0; EQ 9,9 -> res=1, zero=1.
REQ-031 MUL 0x00010000,0x00010000 -> busy 32 cycles, then res=0, zero=1; MULHU same operands -> res=1, zero=0.
REQ-032 DIVU 100,7 -> res=14; REMU 100,7 -> res=2; DIVU 7,0 -> res=0xFFFFFFFF; REMU 7,0 -> res=7.
REQ-033 DIVU 100,7, second start (ADD) and operand changes during busy -> single done, res=14.
REQ-034 MUL started, reset asserted at iteration 10 -> busy=0, done=0, res=0 immediately; ADD 1,1 issued on the first edge after reset release -> res=2, done=1.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/compare/add ops and multi-cycle radix-2
// shift-add multiply and restoring divide, sharing one hi/lo working register pair.
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       iter_op;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opb;

   logic             is_iter;
   logic [WIDTH-1:0] single_res;
   logic             single_zero;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;
   logic [WIDTH-1:0] iter_res;

   function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [WIDTH-1:0]        r;
      sa = a;
      sb = b;
      case (op)
         4'b0000: r = a + b;
         4'b0001: r = a - b;
         4'b0010: r = a & b;
         4'b0011: r = a | b;
         4'b0100: r = {{(WIDTH-1){1'b0}}, (a == b)};
         4'b0101: r = {{(WIDTH-1){1'b0}}, (sa < sb)};
         4'b0110: r = {{(WIDTH-1){1'b0}}, (a < b)};
         4'b0111: r = a ^ b;
         default: r = a;
      endcase
      return r;
   endfunction

   // Compare ops report their boolean in zero; everything else reports res==0.
   function automatic logic zero_flag(input logic [3:0]       op,
                                      input logic [WIDTH-1:0] r);
      if (op == 4'b0100 || op == 4'b0101 || op == 4'b0110)
         return r[0];
      return (r == '0);
   endfunction

   always_comb begin
      is_iter     = (ALUControl[3:2] == 2'b10);
      single_res  = alu_single(ALUControl, srcA, srcB);
      single_zero = zero_flag(ALUControl, single_res);
   end

   // One radix-2 step. Multiply: lo holds the multiplier and shifts right while the
   // product grows into hi. Divide: lo holds the dividend shifting left into hi
   // (the partial remainder) and collects quotient bits at its bottom.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = div_shift[WIDTH-1:0] - opb;
      hi_nxt    = hi;
      lo_nxt    = lo;
      if (!iter_op[1]) begin
         hi_nxt = mul_sum[WIDTH:1];
         lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
      end else if (div_shift >= {1'b0, opb}) begin
         hi_nxt = div_diff;
         lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
         hi_nxt = div_shift[WIDTH-1:0];
         lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
      iter_res = iter_op[0] ? hi_nxt : lo_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         res     <= '0;
         zero    <= 1'b0;
         cnt     <= '0;
         iter_op <= '0;
         hi      <= '0;
         lo      <= '0;
         opb     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_iter) begin
                     state   <= BUSY;
                     busy    <= 1'b1;
                     cnt     <= '0;
                     iter_op <= ALUControl[1:0];
                     hi      <= '0;
                     lo      <= srcA;
                     opb     <= srcB;
                  end else begin
                     res  <= single_res;
                     zero <= single_zero;
                     done <= 1'b1;
                  end
               end
            end
            BUSY: begin
               hi  <= hi_nxt;
               lo  <= lo_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  res   <= iter_res;
                  zero  <= (iter_res == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter (WIDTH=32): directed vector table, randomized ops against an
// arithmetic reference model, and hand-written busy/reset corner sequences.
module tb_alu_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   ALUControl = 4'b0;
   logic [W-1:0] srcA = '0;
   logic [W-1:0] srcB = '0;
   logic [W-1:0] res;
   logic         zero;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   alu_iter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
      .srcA(srcA), .srcB(srcB), .res(res), .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      int           lat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic z, output int lat);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = (a == b) ? 1 : 0;
         4'd5:    r = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd6:    r = (a < b) ? 1 : 0;
         4'd7:    r = a ^ b;
         4'd8:    r = p[31:0];
         4'd9:    r = p[63:32];
         4'd10:   r = (b == 0) ? '1 : a / b;
         4'd11:   r = (b == 0) ? a : a % b;
         default: r = a;
      endcase
      z   = (op inside {4'd4, 4'd5, 4'd6}) ? r[0] : (r == 0);
      lat = (op inside {[4'd8:4'd11]}) ? W : 0;
   endfunction

   // Issues one op, returns the result, edges from acceptance to done, and busy
   // as seen just after acceptance.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output int lat,
                         output logic busy1);
      @(negedge clk);
      ALUControl = op;
      srcA       = a;
      srcB       = b;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy1 = busy;
      lat   = 0;
      while (!done && lat < W + 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = res;
      z = zero;
   endtask

   initial begin
      logic [W-1:0] r, er;
      logic         z, ez, b1;
      int           lat, elat, dones, dlat;

      vecs[0]  = '{4'd0,  32'd5,        32'd7,        32'd12,         1'b0, 0};
      vecs[1]  = '{4'd1,  32'd7,        32'd7,        32'd0,          1'b1, 0};
      vecs[2]  = '{4'd5,  32'hFFFFFFFF, 32'd1,        32'd1,          1'b1, 0};
      vecs[3]  = '{4'd6,  32'hFFFFFFFF, 32'd1,        32'd0,          1'b0, 0};
      vecs[4]  = '{4'd4,  32'd9,        32'd9,        32'd1,          1'b1, 0};
      vecs[5]  = '{4'd8,  32'h00010000, 32'h00010000, 32'd0,          1'b1, 32};
      vecs[6]  = '{4'd9,  32'h00010000, 32'h00010000, 32'd1,          1'b0, 32};
      vecs[7]  = '{4'd10, 32'd100,      32'd7,        32'd14,         1'b0, 32};
      vecs[8]  = '{4'd11, 32'd100,      32'd7,        32'd2,          1'b0, 32};
      vecs[9]  = '{4'd10, 32'd7,        32'd0,        32'hFFFFFFFF,   1'b0, 32};
      vecs[10] = '{4'd11, 32'd7,        32'd0,        32'd7,          1'b0, 32};
      vecs[11] = '{4'd12, 32'h1234,     32'd5,        32'h1234,       1'b0, 0};
      vecs[12] = '{4'd7,  32'hF0F0,     32'hFF00,     32'h0FF0,       1'b0, 0};

      // Asynchronous reset, no clock edge yet
      #1 reset = 1'b1;
      #2;
      chk("reset_res", res, 0);
      chk("reset_zero", zero, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, b1);
         chk($sformatf("vec%0d_res", i), r, vecs[i].res);
         chk($sformatf("vec%0d_zero", i), z, vecs[i].zero);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy", i), b1, (vecs[i].lat > 0));
      end

      // Back-to-back single-cycle ops, one result per cycle
      @(negedge clk);
      ALUControl = 4'd0; srcA = 5; srcB = 7; start = 1'b1;
      @(posedge clk); #1;
      chk("b2b_done0", done, 1);
      chk("b2b_res0", res, 12);
      chk("b2b_zero0", zero, 0);
      ALUControl = 4'd1; srcA = 7; srcB = 7;
      @(posedge clk); #1;
      chk("b2b_done1", done, 1);
      chk("b2b_res1", res, 0);
      chk("b2b_zero1", zero, 1);
      start = 1'b0; srcA = 99;
      @(posedge clk); #1;
      chk("b2b_done_low", done, 0);
      chk("b2b_res_hold", res, 0);

      // Randomized ops against the reference model
      for (int n = 0; n < 60; n++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
         if ($urandom_range(0, 5) == 0) a = b;
         model(op, a, b, er, ez, elat);
         run_op(op, a, b, r, z, lat, b1);
         chk($sformatf("rnd%0d_op%0d_res", n, op), r, er);
         chk($sformatf("rnd%0d_op%0d_zero", n, op), z, ez);
         chk($sformatf("rnd%0d_op%0d_lat", n, op), lat, elat);
      end

      // Start and operand changes during busy are ignored
      @(negedge clk);
      ALUControl = 4'd10; srcA = 100; srcB = 7; start = 1'b1;
      @(posedge clk); #1;
      ALUControl = 4'd0;
      dones = 0; dlat = 0; r = '0;
      for (int i = 1; i <= 40; i++) begin
         if (i % 5 == 0) begin srcA = $urandom; srcB = $urandom; end
         if (i == 20) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            dones++;
            dlat = i;
            r = res;
         end
      end
      chk("busy_ign_dones", dones, 1);
      chk("busy_ign_lat", dlat, 32);
      chk("busy_ign_res", r, 14);

      // Reset mid-iteration aborts, then first edge after release accepts
      @(negedge clk);
      ALUControl = 4'd8; srcA = 32'h0000_1235; srcB = 3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_reset_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_res", res, 0);
      @(negedge clk);
      reset = 1'b0;
      ALUControl = 4'd0; srcA = 1; srcB = 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("post_reset_done", done, 1);
      chk("post_reset_res", res, 2);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("no_stale_done", dones, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
